// File: rtl/axil_regfile_slave_if.sv
// axil_regfile_slave_if: AXI4-Lite bus bundle with master and slave views
interface axil_regfile_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic awvalid, awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic wvalid, wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic bvalid, bready;
   logic [1:0] bresp;
   logic arvalid, arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic rvalid, rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0] rresp;
   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register file, independent channels; AXIL_WSTRB_EN enables byte-strobe writes
module axil_regfile_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REGS   = 16
) (
   input logic clk,
   input logic rst,
   axil_regfile_slave_if.slave s
);
   localparam int SW  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(SW);
   localparam int IW  = ADDR_WIDTH - OFF;
   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
   wr_state_t wr_state;
   rd_state_t rd_state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IW-1:0] aw_q, widx, ridx;
   logic [DATA_WIDTH-1:0] w_q, wr_data, rword;
   logic [SW-1:0] strb_q, strb_in, wr_strb;
   logic aw_hs, w_hs, commit, w_ok, r_ok;
`ifdef AXIL_WSTRB_EN
   assign strb_in = s.wstrb;
`else
   assign strb_in = '1;
`endif
   // a low ready while idle means that channel is already held; the arriving beat is bypassed
   always_comb begin
      aw_hs   = s.awvalid && s.awready;
      w_hs    = s.wvalid && s.wready;
      widx    = aw_hs ? s.awaddr[ADDR_WIDTH-1:OFF] : aw_q;
      wr_data = w_hs ? s.wdata : w_q;
      wr_strb = w_hs ? strb_in : strb_q;
      commit  = wr_state == WR_IDLE && (aw_hs || !s.awready) && (w_hs || !s.wready);
      ridx    = s.araddr[ADDR_WIDTH-1:OFF];
      w_ok    = {1'b0, widx} < (IW+1)'(NUM_REGS);
      r_ok    = {1'b0, ridx} < (IW+1)'(NUM_REGS);
      rword   = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (ridx == IW'(i)) rword = regs[i];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state  <= WR_IDLE;
         rd_state  <= RD_IDLE;
         s.awready <= 1'b1;
         s.wready  <= 1'b1;
         s.arready <= 1'b1;
         s.bvalid  <= 1'b0;
         s.rvalid  <= 1'b0;
         s.bresp   <= 2'b00;
         s.rresp   <= 2'b00;
         s.rdata   <= '0;
         aw_q      <= '0;
         w_q       <= '0;
         strb_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (aw_hs) begin
            aw_q      <= s.awaddr[ADDR_WIDTH-1:OFF];
            s.awready <= 1'b0;
         end
         if (w_hs) begin
            w_q      <= s.wdata;
            strb_q   <= strb_in;
            s.wready <= 1'b0;
         end
         if (commit) begin
            wr_state <= WR_RESP;
            s.bvalid <= 1'b1;
            s.bresp  <= w_ok ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++)
               if (widx == IW'(i))
                  for (int b = 0; b < SW; b++)
                     if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
         end
         if (wr_state == WR_RESP && s.bready) begin
            wr_state  <= WR_IDLE;
            s.bvalid  <= 1'b0;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
         end
         if (rd_state == RD_IDLE && s.arvalid) begin
            rd_state  <= RD_RESP;
            s.rvalid  <= 1'b1;
            s.arready <= 1'b0;
            s.rdata   <= r_ok ? rword : '0;
            s.rresp   <= r_ok ? 2'b00 : 2'b10;
         end
         if (rd_state == RD_RESP && s.rready) begin
            rd_state  <= RD_IDLE;
            s.rvalid  <= 1'b0;
            s.arready <= 1'b1;
         end
      end
   end
endmodule
